// File: rtl/l1_mem_responder.sv
// l1_mem_responder: AXI4 slave backing a Chronos core's l1 master port with a
// local word-addressed RAM. INCR bursts for reads, single-beat and INCR writes,
// plus a host load port used to preload the RAM.
module l1_mem_responder #(
  parameter int unsigned MEM_DEPTH_LOG2 = 14
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  // read address
  input  logic                      s_axi_l1_V_ARVALID,
  output logic                      s_axi_l1_V_ARREADY,
  input  logic [31:0]               s_axi_l1_V_ARADDR,
  input  logic [7:0]                s_axi_l1_V_ARLEN,
  input  logic [2:0]                s_axi_l1_V_ARSIZE,
  // read data
  output logic                      s_axi_l1_V_RVALID,
  input  logic                      s_axi_l1_V_RREADY,
  output logic [31:0]               s_axi_l1_V_RDATA,
  output logic                      s_axi_l1_V_RLAST,
  output logic                      s_axi_l1_V_RID,
  output logic [1:0]                s_axi_l1_V_RRESP,
  // write address
  input  logic                      s_axi_l1_V_AWVALID,
  output logic                      s_axi_l1_V_AWREADY,
  input  logic [31:0]               s_axi_l1_V_AWADDR,
  input  logic [7:0]                s_axi_l1_V_AWLEN,
  input  logic [2:0]                s_axi_l1_V_AWSIZE,
  // write data
  input  logic                      s_axi_l1_V_WVALID,
  output logic                      s_axi_l1_V_WREADY,
  input  logic [31:0]               s_axi_l1_V_WDATA,
  input  logic [3:0]                s_axi_l1_V_WSTRB,
  input  logic                      s_axi_l1_V_WLAST,
  // write response
  output logic                      s_axi_l1_V_BVALID,
  input  logic                      s_axi_l1_V_BREADY,
  output logic [1:0]                s_axi_l1_V_BRESP,
  output logic                      s_axi_l1_V_BID,
  // host load port
  input  logic                      host_wr_en,
  input  logic [MEM_DEPTH_LOG2-1:0] host_wr_addr,
  input  logic [31:0]               host_wr_data,
  output logic                      host_wr_ready
);

  localparam int unsigned AW    = MEM_DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [2:0]  SIZE_WORD = 3'b010;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    WR_RESP
  } state_t;

  state_t            r_state;

  // read burst control
  logic [AW-1:0]     r_raddr;
  logic [8:0]        r_rissue_left;
  logic              r_rsize_err;

  // write burst control
  logic [AW-1:0]     r_waddr;
  logic [7:0]        r_wleft;
  logic              r_wsize_ok;
  logic              r_werr;
  logic              r_bvalid;
  logic [1:0]        r_bresp;

  // RAM and read pipeline
  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_ram_q;
  logic              r_infl;
  logic              r_infl_last;
  logic              r_infl_err;

  // 2-entry read output FIFO
  logic [31:0]       r_fifo_data [2];
  logic              r_fifo_last [2];
  logic [1:0]        r_fifo_resp [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_fifo_cnt;

  logic              w_idle;
  logic              w_host_acc;
  logic              w_wr_start;
  logic              w_rd_start;
  logic              w_wbeat;
  logic              w_aw_size_ok;
  logic              w_first_err;
  logic              w_beat_err;
  logic              w_rvalid;
  logic              w_rpop;
  logic              w_rlast_acc;
  logic [2:0]        w_occ;
  logic              w_rissue;
  logic [AW-1:0]     w_aw_idx;
  logic [AW-1:0]     w_ar_idx;
  logic [AW-1:0]     w_mem_addr;
  logic [31:0]       w_mem_wdata;
  logic [3:0]        w_mem_be;
  logic              w_unused_bits;

  assign w_aw_idx = s_axi_l1_V_AWADDR[AW+1:2];
  assign w_ar_idx = s_axi_l1_V_ARADDR[AW+1:2];
  assign w_unused_bits = &{1'b0, s_axi_l1_V_ARADDR[31:AW+2], s_axi_l1_V_ARADDR[1:0],
                           s_axi_l1_V_AWADDR[31:AW+2], s_axi_l1_V_AWADDR[1:0]};

  // IDLE arbitration: host load, then write (AW+W together), then read.
  // Gating with the reset keeps every ready low while reset is held.
  assign w_idle       = (r_state == IDLE) && ap_rst_n;
  assign w_host_acc   = w_idle && host_wr_en;
  assign w_wr_start   = w_idle && !host_wr_en && s_axi_l1_V_AWVALID && s_axi_l1_V_WVALID;
  assign w_rd_start   = w_idle && !host_wr_en &&
                        !(s_axi_l1_V_AWVALID && s_axi_l1_V_WVALID) && s_axi_l1_V_ARVALID;
  assign w_wbeat      = (r_state == WR_BURST) && s_axi_l1_V_WVALID;
  assign w_aw_size_ok = (s_axi_l1_V_AWSIZE == SIZE_WORD);
  assign w_first_err  = !w_aw_size_ok || (s_axi_l1_V_WLAST != (s_axi_l1_V_AWLEN == 8'd0));
  assign w_beat_err   = (s_axi_l1_V_WLAST != (r_wleft == 8'd1));

  assign w_rvalid    = (r_fifo_cnt != 2'd0);
  assign w_rpop      = w_rvalid && s_axi_l1_V_RREADY;
  assign w_rlast_acc = w_rpop && r_fifo_last[r_rd_ptr];
  // Occupancy counts the slot freed by this cycle's pop, which is what allows
  // one beat per cycle while still never overflowing the two entries.
  assign w_occ    = {1'b0, r_fifo_cnt} + {2'b00, r_infl} - {2'b00, w_rpop};
  assign w_rissue = (r_state == RD_BURST) && (r_rissue_left != 9'd0) && (w_occ < 3'd2);

  assign s_axi_l1_V_ARREADY = w_rd_start;
  assign s_axi_l1_V_AWREADY = w_wr_start;
  assign s_axi_l1_V_WREADY  = w_wr_start || (r_state == WR_BURST);
  assign host_wr_ready      = w_idle;
  assign s_axi_l1_V_RVALID  = w_rvalid;
  assign s_axi_l1_V_RDATA   = r_fifo_data[r_rd_ptr];
  assign s_axi_l1_V_RLAST   = r_fifo_last[r_rd_ptr];
  assign s_axi_l1_V_RRESP   = r_fifo_resp[r_rd_ptr];
  assign s_axi_l1_V_RID     = 1'b0;
  assign s_axi_l1_V_BVALID  = r_bvalid;
  assign s_axi_l1_V_BRESP   = r_bresp;
  assign s_axi_l1_V_BID     = 1'b0;

  // Single RAM write port shared by host loads and AXI write beats
  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_be    = '0;
    if (w_host_acc) begin
      w_mem_addr  = host_wr_addr;
      w_mem_wdata = host_wr_data;
      w_mem_be    = '1;
    end else if (w_wr_start && w_aw_size_ok) begin
      w_mem_addr  = w_aw_idx;
      w_mem_wdata = s_axi_l1_V_WDATA;
      w_mem_be    = s_axi_l1_V_WSTRB;
    end else if (w_wbeat && r_wsize_ok) begin
      w_mem_addr  = r_waddr;
      w_mem_wdata = s_axi_l1_V_WDATA;
      w_mem_be    = s_axi_l1_V_WSTRB;
    end
  end

  // Transaction state machine
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= IDLE;
      r_raddr       <= '0;
      r_rissue_left <= '0;
      r_rsize_err   <= 1'b0;
      r_waddr       <= '0;
      r_wleft       <= '0;
      r_wsize_ok    <= 1'b0;
      r_werr        <= 1'b0;
      r_bvalid      <= 1'b0;
      r_bresp       <= RESP_OKAY;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_start) begin
            r_waddr    <= w_aw_idx + 1'b1;
            r_wleft    <= s_axi_l1_V_AWLEN;
            r_wsize_ok <= w_aw_size_ok;
            r_werr     <= w_first_err;
            if (s_axi_l1_V_AWLEN == 8'd0) begin
              r_state  <= WR_RESP;
              r_bvalid <= 1'b1;
              r_bresp  <= w_first_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
              r_state  <= WR_BURST;
            end
          end else if (w_rd_start) begin
            r_raddr       <= w_ar_idx;
            r_rissue_left <= {1'b0, s_axi_l1_V_ARLEN} + 9'd1;
            r_rsize_err   <= (s_axi_l1_V_ARSIZE != SIZE_WORD);
            r_state       <= RD_BURST;
          end
        end
        WR_BURST: begin
          if (s_axi_l1_V_WVALID) begin
            r_waddr <= r_waddr + 1'b1;
            r_wleft <= r_wleft - 8'd1;
            if (r_wleft == 8'd1) begin
              r_state  <= WR_RESP;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_werr || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              r_werr   <= r_werr || w_beat_err;
            end
          end
        end
        WR_RESP: begin
          if (s_axi_l1_V_BREADY) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RD_BURST: begin
          if (w_rissue) begin
            r_raddr       <= r_raddr + 1'b1;
            r_rissue_left <= r_rissue_left - 9'd1;
          end
          if (w_rlast_acc) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM array: byte-enabled write, registered read (contents not reset)
  always_ff @(posedge ap_clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (w_mem_be[b]) begin
        r_mem[w_mem_addr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
      end
    end
    if (w_rissue) begin
      r_ram_q <= r_mem[r_raddr];
    end
  end

  // Track the in-flight RAM read and move it into the output FIFO
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_infl         <= 1'b0;
      r_infl_last    <= 1'b0;
      r_infl_err     <= 1'b0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_fifo_resp[0] <= RESP_OKAY;
      r_fifo_resp[1] <= RESP_OKAY;
      r_rd_ptr       <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_fifo_cnt     <= '0;
    end else begin
      r_infl      <= w_rissue;
      r_infl_last <= (r_rissue_left == 9'd1);
      r_infl_err  <= r_rsize_err;
      if (r_infl) begin
        r_fifo_data[r_wr_ptr] <= r_infl_err ? '0 : r_ram_q;
        r_fifo_last[r_wr_ptr] <= r_infl_last;
        r_fifo_resp[r_wr_ptr] <= r_infl_err ? RESP_SLVERR : RESP_OKAY;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_rpop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_fifo_cnt <= r_fifo_cnt + {1'b0, r_infl} - {1'b0, w_rpop};
    end
  end

endmodule

// File: tb/tb_l1_mem_responder.sv
// Scoreboard bench for l1_mem_responder: directed transactions push expected
// R beats / B responses; a negedge monitor pops and compares on handshakes.
module tb_l1_mem_responder;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST, RID;
  logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
  logic [7:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  RRESP, BRESP;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY, BID;
  logic [3:0]  WSTRB;
  logic        host_wr_en, host_wr_ready;
  logic [13:0] host_wr_addr;
  logic [31:0] host_wr_data;

  always #5 ap_clk = ~ap_clk;

  l1_mem_responder #(.MEM_DEPTH_LOG2(14)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axi_l1_V_ARVALID(ARVALID), .s_axi_l1_V_ARREADY(ARREADY),
    .s_axi_l1_V_ARADDR(ARADDR), .s_axi_l1_V_ARLEN(ARLEN), .s_axi_l1_V_ARSIZE(ARSIZE),
    .s_axi_l1_V_RVALID(RVALID), .s_axi_l1_V_RREADY(RREADY), .s_axi_l1_V_RDATA(RDATA),
    .s_axi_l1_V_RLAST(RLAST), .s_axi_l1_V_RID(RID), .s_axi_l1_V_RRESP(RRESP),
    .s_axi_l1_V_AWVALID(AWVALID), .s_axi_l1_V_AWREADY(AWREADY),
    .s_axi_l1_V_AWADDR(AWADDR), .s_axi_l1_V_AWLEN(AWLEN), .s_axi_l1_V_AWSIZE(AWSIZE),
    .s_axi_l1_V_WVALID(WVALID), .s_axi_l1_V_WREADY(WREADY), .s_axi_l1_V_WDATA(WDATA),
    .s_axi_l1_V_WSTRB(WSTRB), .s_axi_l1_V_WLAST(WLAST),
    .s_axi_l1_V_BVALID(BVALID), .s_axi_l1_V_BREADY(BREADY), .s_axi_l1_V_BRESP(BRESP),
    .s_axi_l1_V_BID(BID),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_wr_ready(host_wr_ready)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [1:0]  r;
  } rexp_t;

  rexp_t      rq[$];
  logic [1:0] bq[$];
  int         r_cyc[$];
  int         b_cyc[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         r_seen = 0;
  int         b_seen = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void push_r(input logic [31:0] d, input logic l, input logic [1:0] r);
    rexp_t e;
    e.d = d; e.l = l; e.r = r;
    rq.push_back(e);
  endfunction

  // Monitor: compares every R/B handshake against the scoreboard and checks
  // that a stalled R beat stays put.
  logic        stall_q = 1'b0;
  logic [34:0] held;
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("r_valid_held", RVALID, 1);
        chk("r_stable", {RRESP, RLAST, RDATA}, held);
      end
      if (RVALID && RREADY) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL r_extra_beat actual=0x%0h required=none", RDATA);
        end else begin
          rexp_t e;
          e = rq.pop_front();
          chk("r_beat", {RRESP, RLAST, RDATA}, {e.r, e.l, e.d});
          chk("r_id", RID, 0);
        end
        r_seen++;
        r_cyc.push_back(cyc);
      end
      stall_q = RVALID && !RREADY;
      held = {RRESP, RLAST, RDATA};
      if (BVALID && BREADY) begin
        if (bq.size() == 0) begin
          total++; bad++;
          $display("FAIL b_extra actual=0x%0h required=none", BRESP);
        end else begin
          chk("b_resp", {BID, BRESP}, {1'b0, bq.pop_front()});
        end
        b_seen++;
        b_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_ready(input int which, input string nm);
    logic rdy;
    rdy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ap_clk);
      case (which)
        0: rdy = ARREADY;
        1: rdy = AWREADY;
        2: rdy = WREADY;
        default: rdy = host_wr_ready;
      endcase
      if (rdy) break;
    end
    if (!rdy) begin
      total++; bad++;
      $display("FAIL %s timeout actual=0 required=1", nm);
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_cnt(input int which, input int target, input string nm);
    int n;
    for (int i = 0; i < 300; i++) begin
      n = (which == 0) ? r_seen : b_seen;
      if (n >= target) break;
      @(posedge ap_clk);
      #1;
    end
    n = (which == 0) ? r_seen : b_seen;
    if (n < target) begin
      total++; bad++;
      $display("FAIL %s timeout actual=%0d required=%0d", nm, n, target);
    end
  endtask

  task automatic host_load(input logic [13:0] a, input logic [31:0] d);
    host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
    wait_ready(3, "host_load");
    host_wr_en = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                       output int n);
    ARVALID = 1'b1; ARADDR = a; ARLEN = len; ARSIZE = sz;
    wait_ready(0, "ar_hs");
    ARVALID = 1'b0;
    n = cyc;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [3:0] st, input logic [1:0] wl, output int wc);
    AWVALID = 1'b1; AWADDR = a; AWLEN = len; AWSIZE = sz;
    WVALID = 1'b1; WDATA = d0; WSTRB = st; WLAST = wl[0];
    wait_ready(1, "aw_hs");
    AWVALID = 1'b0;
    if (len != 8'd0) begin
      WDATA = d1; WLAST = wl[1];
      wait_ready(2, "w_hs");
    end
    WVALID = 1'b0;
    wc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wc, base, bb, k;
    // Valids high during reset: nothing may be accepted.
    ARVALID = 1'b1; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010;
    AWVALID = 1'b1; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010;
    WVALID = 1'b1; WDATA = '0; WSTRB = '0; WLAST = 1'b1;
    RREADY = 1'b1; BREADY = 1'b1;
    host_wr_en = 1'b1; host_wr_addr = '0; host_wr_data = '0;
    #12;
    chk("rst_readys", {ARREADY, AWREADY, WREADY, host_wr_ready}, 0);
    chk("rst_valids", {RVALID, BVALID}, 0);
    chk("rst_rfields", {RLAST, RRESP, RDATA}, 0);
    chk("rst_bresp", BRESP, 0);
    ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; host_wr_en = 1'b0;
    #5 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk("idle_after_rst", host_wr_ready, 1);

    // Host load then single read; first RVALID two cycles after AR.
    host_load(14'd3, 32'h40);
    base = r_seen;
    push_r(32'h40, 1'b1, 2'b00);
    do_ar(32'hC, 8'd0, 3'b010, n);
    wait_cnt(0, base + 1, "rd_single");
    chk("rd_latency", r_cyc[base], n + 2);

    // 8-beat burst with RREADY 1,0,0 pattern.
    for (int i = 0; i < 8; i++) host_load(14'(100 + i), 32'(i));
    base = r_seen;
    for (int i = 0; i < 8; i++) push_r(32'(i), (i == 7), 2'b00);
    do_ar(32'd400, 8'd7, 3'b010, n);
    k = 0;
    for (int i = 0; i < 200 && r_seen < base + 8; i++) begin
      RREADY = (k % 3 == 0);
      @(posedge ap_clk); #1;
      k++;
    end
    RREADY = 1'b1;
    chk("burst_bp_count", r_seen, base + 8);

    // Same burst at full rate: 8 beats in 8 consecutive cycles.
    base = r_seen;
    for (int i = 0; i < 8; i++) push_r(32'(i), (i == 7), 2'b00);
    do_ar(32'd400, 8'd7, 3'b010, n);
    wait_cnt(0, base + 8, "burst_full");
    chk("burst_first", r_cyc[base], n + 2);
    chk("burst_span", r_cyc[base + 7] - r_cyc[base], 7);

    // Byte-strobed write, B timing, readback.
    host_load(14'd8, 32'h11223344);
    bb = b_seen;
    bq.push_back(2'b00);
    do_write(32'h20, 8'd0, 3'b010, 32'hDEADBEEF, 32'h0, 4'b0011, 2'b01, wc);
    wait_cnt(1, bb + 1, "b_single");
    chk("b_timing", b_cyc[bb], wc);
    base = r_seen;
    push_r(32'h1122BEEF, 1'b1, 2'b00);
    do_ar(32'h20, 8'd0, 3'b010, n);
    wait_cnt(0, base + 1, "rd_strobe");

    // AR and AW+W together on the same address: write first.
    host_load(14'd16, 32'h5555AAAA);
    bb = b_seen; base = r_seen;
    bq.push_back(2'b00);
    push_r(32'h0BADF00D, 1'b1, 2'b00);
    ARVALID = 1'b1; ARADDR = 32'h40; ARLEN = 8'd0; ARSIZE = 3'b010;
    AWVALID = 1'b1; AWADDR = 32'h40; AWLEN = 8'd0; AWSIZE = 3'b010;
    WVALID = 1'b1; WDATA = 32'h0BADF00D; WSTRB = 4'hF; WLAST = 1'b1;
    @(negedge ap_clk);
    chk("coll_aw_w_ready", {AWREADY, WREADY}, 2'b11);
    chk("coll_ar_held", ARREADY, 0);
    @(posedge ap_clk); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    wait_ready(0, "coll_ar");
    ARVALID = 1'b0;
    n = cyc;
    wait_cnt(1, bb + 1, "coll_b");
    chk("coll_ar_after_b", n, b_cyc[bb] + 2);
    wait_cnt(0, base + 1, "coll_r");

    // Bad read size: SLVERR beats with zero data.
    base = r_seen;
    push_r(32'h0, 1'b0, 2'b10);
    push_r(32'h0, 1'b1, 2'b10);
    do_ar(32'hC, 8'd1, 3'b001, n);
    wait_cnt(0, base + 2, "rd_badsize");

    // WLAST on beat 0 of a 2-beat write: data lands, BRESP=SLVERR.
    host_load(14'd20, 32'h12345678);
    host_load(14'd21, 32'h9ABCDEF0);
    bb = b_seen;
    bq.push_back(2'b10);
    do_write(32'h50, 8'd1, 3'b010, 32'hA1, 32'hA2, 4'hF, 2'b01, wc);
    wait_cnt(1, bb + 1, "b_wlast_err");
    // Bad write size: nothing written, BRESP=SLVERR.
    bb = b_seen;
    bq.push_back(2'b10);
    do_write(32'h50, 8'd0, 3'b001, 32'hFF, 32'h0, 4'hF, 2'b01, wc);
    wait_cnt(1, bb + 1, "b_badsize");
    // Well-formed 2-beat write.
    bb = b_seen;
    bq.push_back(2'b00);
    do_write(32'h58, 8'd1, 3'b010, 32'hC0DE0001, 32'hC0DE0002, 4'hF, 2'b10, wc);
    wait_cnt(1, bb + 1, "b_burst");
    base = r_seen;
    push_r(32'hA1, 1'b0, 2'b00);
    push_r(32'hA2, 1'b0, 2'b00);
    push_r(32'hC0DE0001, 1'b0, 2'b00);
    push_r(32'hC0DE0002, 1'b1, 2'b00);
    do_ar(32'h50, 8'd3, 3'b010, n);
    wait_cnt(0, base + 4, "rd_wback");

    // Address wrap at top of RAM, upper address bits ignored.
    host_load(14'd16383, 32'hCAFEF00D);
    host_load(14'd0, 32'h01020304);
    base = r_seen;
    push_r(32'hCAFEF00D, 1'b0, 2'b00);
    push_r(32'h01020304, 1'b1, 2'b00);
    do_ar(32'h8000FFFC, 8'd1, 3'b010, n);
    wait_cnt(0, base + 2, "rd_wrap");

    // Reset during beat 3 of an 8-beat read.
    base = r_seen;
    for (int i = 0; i < 8; i++) push_r(32'(i), (i == 7), 2'b00);
    do_ar(32'd400, 8'd7, 3'b010, n);
    wait_cnt(0, base + 3, "rd_pre_rst");
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", RVALID, 0);
    chk("midrst_ready", {host_wr_ready, ARREADY}, 0);
    rq.delete();
    @(posedge ap_clk);
    @(posedge ap_clk); #2;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk("midrst_idle", host_wr_ready, 1);
    repeat (3) @(posedge ap_clk);
    #1;
    chk("midrst_no_beats", r_seen, base + 3);
    base = r_seen;
    push_r(32'd1, 1'b0, 2'b00);
    push_r(32'd2, 1'b1, 2'b00);
    do_ar(32'd404, 8'd1, 3'b010, n);
    wait_cnt(0, base + 2, "rd_post_rst");

    repeat (4) @(posedge ap_clk);
    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
